vx_icache_responder: RTL and testbench

Memory-side responder for the icache request/response protocol: it answers fetch requests from the icache stage with instruction words. Each accepted request is answered in order, with its tag returned unchanged, after a fixed latency. A credit-limited response queue absorbs backpressure. The block serves as the core's instruction memory model in simulation and in small FPGA configurations. Contents are preloaded through a dedicated write port.

---
 rtl/vx_icache_responder.sv | 131 +++++++++++++
 tb/tb_vx_icache_responder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vx_icache_responder.sv
// Instruction-memory responder: answers icache fetches in order after a fixed
// latency, with a credit-limited response FIFO and a preload write port.
module vx_icache_responder #(
    parameter int WORDS       = 1024,
    parameter int TAG_WIDTH   = 16,
    parameter int LATENCY     = 2,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    input  logic [29:0]                      req_addr,
    input  logic [TAG_WIDTH-1:0]             req_tag,
    output logic                             req_ready,
    output logic                             rsp_valid,
    output logic [31:0]                      rsp_data,
    output logic [TAG_WIDTH-1:0]             rsp_tag,
    input  logic                             rsp_ready,
    input  logic                             load_en,
    input  logic [$clog2(WORDS)-1:0]         load_addr,
    input  logic [31:0]                      load_data,
    output logic [$clog2(QUEUE_DEPTH):0]     pending
);
    localparam int AW  = $clog2(WORDS);
    localparam int PW  = $clog2(QUEUE_DEPTH) + 1;
    localparam int QAW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int EW  = TAG_WIDTH + 32;

    logic [31:0] mem [WORDS];

    logic [LATENCY-1:0]                pv_q, pv_d;
    logic [LATENCY-1:0][TAG_WIDTH-1:0] pt_q, pt_d;
    logic [LATENCY-1:0][31:0]          pd_q, pd_d;

    logic [QUEUE_DEPTH-1:0][EW-1:0] fq_q, fq_d;
    logic [QAW-1:0]                 wp_q, wp_d, rp_q, rp_d;
    logic [PW-1:0]                  cnt_q, cnt_d;
    logic [PW-1:0]                  pending_q, pending_d;

    logic req_fire, rsp_fire, last_v, fifo_empty, push, pop;
    logic unused_addr_hi;

    assign unused_addr_hi = ^req_addr[29:AW];

    function automatic logic [QAW-1:0] ptr_inc(input logic [QAW-1:0] p);
        return (p == QAW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Gating with reset keeps req_ready low for the whole time reset is held.
    assign req_ready  = reset && (pending_q < PW'(QUEUE_DEPTH));
    assign req_fire   = req_valid && req_ready;
    assign last_v     = pv_q[LATENCY-1];
    assign fifo_empty = (cnt_q == '0);
    assign rsp_valid  = !fifo_empty || last_v;
    assign rsp_fire   = rsp_valid && rsp_ready;
    // The final stage bypasses only when the FIFO is empty and the consumer takes it.
    assign push       = last_v && !(fifo_empty && rsp_ready);
    assign pop        = !fifo_empty && rsp_ready;
    assign pending    = pending_q;

    always_comb begin
        rsp_data = '0;
        rsp_tag  = '0;
        if (!fifo_empty) begin
            {rsp_tag, rsp_data} = fq_q[rp_q];
        end else if (last_v) begin
            rsp_tag  = pt_q[LATENCY-1];
            rsp_data = pd_q[LATENCY-1];
        end
    end

    always_comb begin
        pv_d    = '0;
        pt_d    = '0;
        pd_d    = '0;
        pv_d[0] = req_fire;
        if (req_fire) begin
            pt_d[0] = req_tag;
            pd_d[0] = mem[req_addr[AW-1:0]];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pt_d[i] = pt_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
    end

    always_comb begin
        fq_d      = fq_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        cnt_d     = cnt_q + PW'(push) - PW'(pop);
        pending_d = pending_q + PW'(req_fire) - PW'(rsp_fire);
        if (push) begin
            fq_d[wp_q] = {pt_q[LATENCY-1], pd_q[LATENCY-1]};
            wp_d       = ptr_inc(wp_q);
        end
        if (pop) begin
            rp_d = ptr_inc(rp_q);
        end
    end

    // Read-first: the pipeline samples the old word on the same edge that writes.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv_q      <= '0;
            pt_q      <= '0;
            pd_q      <= '0;
            fq_q      <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            pv_q      <= pv_d;
            pt_q      <= pt_d;
            pd_q      <= pd_d;
            fq_q      <= fq_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_vx_icache_responder.sv
// Bench for vx_icache_responder: directed and random fetches against a RAM
// model with an in-order expected-response queue checked by a monitor.
module tb_vx_icache_responder;
    localparam int WORDS = 1024;
    localparam int TW    = 16;
    localparam int LAT   = 2;
    localparam int QD    = 4;
    localparam int AW    = $clog2(WORDS);
    localparam int PW    = $clog2(QD) + 1;
    localparam int EW    = 1 + 32 + TW + 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic [29:0]   req_addr;
    logic [TW-1:0] req_tag;
    logic          req_ready;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_ready;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [PW-1:0] pending;

    vx_icache_responder #(.WORDS(WORDS), .TAG_WIDTH(TW), .LATENCY(LAT), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .pending(pending)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int model_pending = 0;
    bit head_seen = 1'b0;
    logic [31:0]   model_mem [WORDS];
    logic [EW-1:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic          e_alone;
        int            e_acc;
        logic [TW-1:0] e_tag;
        logic [31:0]   e_data;
        bit            rf;
        if (!reset) begin
            chk("reset_rsp_valid", rsp_valid, 0);
            chk("reset_pending", pending, 0);
            chk("reset_req_ready", req_ready, 0);
            exp_q.delete();
            model_pending = 0;
            head_seen = 1'b0;
        end else begin
            chk("pending", pending, model_pending);
            chk("req_ready", req_ready, model_pending < QD);
            rf = 1'b0;
            if (exp_q.size() == 0) begin
                chk("no_rsp_expected", rsp_valid, 0);
            end else if (rsp_valid) begin
                e = exp_q[0];
                {e_alone, e_acc, e_tag, e_data} = e;
                chk("rsp_tag", rsp_tag, e_tag);
                chk("rsp_data", rsp_data, e_data);
                if (!head_seen) begin
                    chk("lat_not_early", cyc >= e_acc + LAT, 1);
                    if (e_alone) chk("lat_exact", cyc, e_acc + LAT);
                    head_seen = 1'b1;
                end
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    head_seen = 1'b0;
                    rf = 1'b1;
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back({(model_pending == 0), cyc, req_tag,
                                 model_mem[req_addr % WORDS]});
                model_pending++;
            end
            if (rf) model_pending--;
            if (load_en) model_mem[load_addr] = load_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [29:0] a, input logic [TW-1:0] t);
        bit acc = 1'b0;
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_tag   = t;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = req_ready;
            tick();
            n++;
        end
        req_valid = 1'b0;
        chk("req_accept_timeout", acc, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0;
        rsp_ready = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) tick();
        reset = 1'b1;

        for (int i = 0; i < WORDS; i++) begin
            load_en   = 1'b1;
            load_addr = AW'(i);
            load_data = (i == 5) ? 32'h0050_0093 : (i == 6) ? 32'h0000_0013 :
                        (i == 7) ? 32'h1111_1111 : $urandom;
            tick();
        end
        load_en = 1'b0;
        repeat (2) tick();

        // Single fetch, then back-to-back fetches.
        send(30'd5, 16'h000A);
        drain();
        send(30'd5, 16'h0001);
        send(30'd6, 16'h0002);
        send(30'd5, 16'h0003);
        drain();

        // Backpressure: requests every cycle while the consumer stalls.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 30'($urandom_range(0, 31));
            req_tag  = TW'(16'h20 + i);
            tick();
        end
        req_valid = 1'b0;
        repeat (3) tick();
        rsp_ready = 1'b1;
        drain();

        // Same-cycle preload and fetch of index 7, then a fresh fetch.
        load_en = 1'b1; load_addr = AW'(7); load_data = 32'hDEAD_BEEF;
        send(30'd7, 16'h0070);
        load_en = 1'b0;
        send(30'd7, 16'h0071);
        send(30'h400, 16'h0400);
        drain();

        // Random traffic with random backpressure and occasional preloads.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = 30'($urandom);
            req_tag   = TW'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            load_en   = ($urandom_range(0, 15) == 0);
            load_addr = AW'($urandom);
            load_data = $urandom;
            tick();
        end
        req_valid = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
        drain();

        // Reset with three requests outstanding.
        rsp_ready = 1'b0;
        send(30'd1, 16'h0B01);
        send(30'd2, 16'h0B02);
        send(30'd3, 16'h0B03);
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        rsp_ready = 1'b1;
        repeat (20) tick();
        send(30'd6, 16'h0C00);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
